// File: rtl/coder_pkg.sv
// Package: coder_pkg
// Shared definitions for the one-hot decoder / sequential encoder pair.
//   state_e    : encoder FSM states (IDLE accepts a vector, EMIT streams indices)
//   lsb_t      : result of a lowest-set-bit search (index + found flag)
//   lsb_index  : lowest set-bit index of a vector, with found flag
//   onehot     : true when exactly one bit of a vector is set
// The helpers operate on vectors zero-extended to MAX_W bits, so any
// instance width up to MAX_W can share them.
package coder_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             found;
  } lsb_t;

  // Scanning from the top down means the last hit written is the lowest one.
  function automatic lsb_t lsb_index(input logic [MAX_W-1:0] vec);
    lsb_t r;
    r = '0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.idx   = IDX_W'(i);
        r.found = 1'b1;
      end
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves zero only if it was the only one.
  function automatic logic onehot(input logic [MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Module: prio_enc_lsb
// Combinational lowest-set-bit finder.
//   vec    in  u  vector to search
//   index  out n  index of the lowest set bit (0 when none set)
//   found  out 1  at least one bit set
//   single out 1  exactly one bit set
module prio_enc_lsb
  import coder_pkg::*;
#(
  parameter int n = 4,
  parameter int u = 8
) (
  input  logic [u-1:0] vec,
  output logic [n-1:0] index,
  output logic         found,
  output logic         single
);

  generate
    if ((u < 1) || (u > (1 << n)) || (u > MAX_W)) begin : g_bad_params
      $error("prio_enc_lsb: u must satisfy 1 <= u <= 2**n and u <= MAX_W");
    end
  endgenerate

  lsb_t lsb;

  always_comb begin
    lsb    = lsb_index(MAX_W'(vec));
    index  = n'(lsb.idx);
    found  = lsb.found;
    single = onehot(MAX_W'(vec));
  end

endmodule

// File: rtl/encode_scan.sv
// Module: encode_scan
// Sequential encoder: captures a u-bit request vector and emits the binary
// index of every set bit, lowest first, one index per valid/ready beat.
// An all-zero vector produces a single beat flagged with y_none.
//   clk      in   1  clock, all logic on posedge
//   rst      in   1  synchronous active-high reset
//   x_in     in   u  request vector, sampled on x_valid && x_ready
//   x_valid  in   1  x_in valid
//   x_ready  out  1  idle, can accept a vector
//   y_out    out  n  index of the current set bit
//   y_valid  out  1  y_out / y_last / y_none valid
//   y_ready  in   1  consumer accepts the current beat
//   y_last   out  1  current beat is the final one for this vector
//   y_none   out  1  captured vector was all-zero
module encode_scan
  import coder_pkg::*;
#(
  parameter int n = 4,
  parameter int u = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [u-1:0] x_in,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [n-1:0] y_out,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         y_last,
  output logic         y_none
);

  generate
    if ((u < 1) || (u > (1 << n))) begin : g_bad_params
      $error("encode_scan: u must satisfy 1 <= u <= 2**n");
    end
  endgenerate

  state_e         state_q,   state_d;
  logic [u-1:0]   pending_q, pending_d;
  logic [n-1:0]   y_out_q,   y_out_d;
  logic           y_last_q,  y_last_d;
  logic           y_none_q,  y_none_d;

  logic [n-1:0]   enc_index;
  logic           enc_found;
  logic           enc_single;

  // Next pending set: a fresh capture in IDLE, or the lowest bit (the one
  // currently on y_out) cleared on each accepted beat in EMIT. Kept in its
  // own process so the encoder sits between two combinational blocks
  // rather than inside a loop.
  always_comb begin
    pending_d = pending_q;
    if (state_q == IDLE) begin
      if (x_valid) pending_d = x_in;
    end else if (y_ready) begin
      pending_d = pending_q & (pending_q - u'(1));
    end
  end

  // Looking at the next pending value lets the index be registered, so
  // y_out comes straight from a flop with one beat per clock.
  prio_enc_lsb #(.n(n), .u(u)) u_prio_enc (
    .vec    (pending_d),
    .index  (enc_index),
    .found  (enc_found),
    .single (enc_single)
  );

  // NOTE: every signal assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    y_out_d  = y_out_q;
    y_last_d = y_last_q;
    y_none_d = y_none_q;
    unique case (state_q)
      IDLE: begin
        if (x_valid) begin
          state_d  = EMIT;
          y_out_d  = enc_index;
          y_last_d = enc_single || !enc_found;
          y_none_d = !enc_found;
        end
      end
      EMIT: begin
        if (y_ready) begin
          if (y_last_q) begin
            // y_out deliberately holds its last value.
            state_d  = IDLE;
            y_last_d = 1'b0;
            y_none_d = 1'b0;
          end else begin
            y_out_d  = enc_index;
            y_last_d = enc_single;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      y_out_q   <= '0;
      y_last_q  <= 1'b0;
      y_none_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      y_out_q   <= y_out_d;
      y_last_q  <= y_last_d;
      y_none_q  <= y_none_d;
    end
  end

  // x_ready is gated by rst so no vector is offered a handshake during reset.
  assign x_ready = (state_q == IDLE) && !rst;
  assign y_valid = (state_q == EMIT);
  assign y_out   = y_out_q;
  assign y_last  = y_last_q;
  assign y_none  = y_none_q;

endmodule
